// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with glitch-free ratio updates.
// Ratio changes are staged and applied only at period boundaries or on sync_all.
module prog_clock_divider #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              sync_all,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO  = DIV_W'(2);
  localparam logic [DIV_W-1:0] DEFR = DIV_W'(DEFAULT_DIV);

  logic [NUM_CH-1:0] pend_v;

  // Out-of-range channel indices never match, so they read as ready.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pend_v[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] r_q, r_d;
    logic [DIV_W-1:0] pr_q, pr_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             act;
    logic             wrap;
    logic             bnd;
    logic             wr;
    logic [DIV_W-1:0] inc;
    logic [DIV_W-1:0] half;

    always_comb begin
      act    = (r_q >= TWO);
      wrap   = act && (cnt_q == r_q - ONE);
      bnd    = !act || wrap;
      wr     = cfg_valid && cfg_ready
               && (cfg_ch == CH_W'(g));
      inc    = wrap ? '0 : cnt_q + ONE;
      half   = r_q >> 1;
      cnt_d  = cnt_q;
      r_d    = r_q;
      pr_d   = pr_q;
      pend_d = pend_q;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      if (sync_all) begin
        cnt_d = '0;
        if (pend_q) begin
          r_d    = pr_q;
          pend_d = 1'b0;
        end
      end else if (pend_q && bnd) begin
        // Boundary edge: the old period has just ended low.
        r_d    = pr_q;
        pend_d = 1'b0;
        cnt_d  = '0;
        tick_d = wrap;
      end else if (act) begin
        cnt_d  = inc;
        clk_d  = (inc >= half);
        tick_d = wrap;
      end else begin
        cnt_d = '0;
      end
      if (wr) begin
        pend_d = 1'b1;
        pr_d   = cfg_div;
      end
    end

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        r_q    <= DEFR;
        pr_q   <= DEFR;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        r_q    <= r_d;
        pr_q   <= pr_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign pend_v[g]  = pend_q;
    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: defaults, ratio writes,
// disable, sync_all alignment and asynchronous reset.
module tb_prog_clock_divider;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       sync_all = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [0:0] cfg_ch = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic [1:0] clk_out;
  logic [1:0] tick;

  int n_chk = 0;
  int n_pass = 0;

  prog_clock_divider #(
    .NUM_CH(2),
    .DIV_W(8),
    .DEFAULT_DIV(2)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .sync_all(sync_all),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_sync();
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    step();
    step();
    n_chk++;
    if (clk_out !== 2'b00 || tick !== 2'b00)
      $display("FAIL rst_out clk=%b tick=%b want 00/00", clk_out, tick);
    else n_pass++;
    cfg_ch = 1'b0;
    n_chk++;
    if (cfg_ready !== 1'b1)
      $display("FAIL rst_ready got %b want 1", cfg_ready);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_default();
    logic [1:0] ec, et;
    for (int k = 1; k <= 10; k++) begin
      step();
      ec = (k % 2 == 1) ? 2'b11 : 2'b00;
      et = (k % 2 == 0) ? 2'b11 : 2'b00;
      n_chk++;
      if (clk_out !== ec || tick !== et)
        $display("FAIL default_e%0d clk=%b tick=%b want %b/%b",
                 k, clk_out, tick, ec, et);
      else n_pass++;
    end
  endtask

  task automatic test_write_ch0();
    bit [0:10] c0 = 11'b10011100111;
    bit [0:10] t0 = 11'b01000010000;
    bit [0:10] c1 = 11'b10101010101;
    bit [0:10] t1 = 11'b01010101010;
    do_sync();
    cfg_valid = 1'b1;
    cfg_ch = 1'b0;
    cfg_div = 8'd5;
    n_chk++;
    if (cfg_ready !== 1'b1)
      $display("FAIL wr_ready_pre got %b want 1", cfg_ready);
    else n_pass++;
    for (int k = 0; k <= 10; k++) begin
      step();
      if (k == 0) begin
        cfg_div = 8'd7;
        n_chk++;
        if (cfg_ready !== 1'b0)
          $display("FAIL wr_ready_pend got %b want 0", cfg_ready);
        else n_pass++;
      end
      if (k == 1) begin
        n_chk++;
        if (cfg_ready !== 1'b1)
          $display("FAIL wr_ready_post got %b want 1", cfg_ready);
        else n_pass++;
        cfg_valid = 1'b0;
      end
      n_chk++;
      if (clk_out !== {c1[k], c0[k]} || tick !== {t1[k], t0[k]})
        $display("FAIL wr5_e%0d clk=%b tick=%b want %b%b/%b%b",
                 k, clk_out, tick, c1[k], c0[k], t1[k], t0[k]);
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    bit [0:4] cd = 5'b10000;
    bit [0:4] td = 5'b01000;
    bit [0:6] ce = 7'b0001100;
    bit [0:6] te = 7'b0000010;
    do_sync();
    cfg_valid = 1'b1;
    cfg_ch = 1'b1;
    cfg_div = 8'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      cfg_valid = 1'b0;
      n_chk++;
      if (clk_out[1] !== cd[k] || tick[1] !== td[k])
        $display("FAIL dis_e%0d clk1=%b tick1=%b want %b/%b",
                 k, clk_out[1], tick[1], cd[k], td[k]);
      else n_pass++;
    end
    cfg_valid = 1'b1;
    cfg_div = 8'd4;
    for (int k = 0; k < 7; k++) begin
      step();
      cfg_valid = 1'b0;
      n_chk++;
      if (clk_out[1] !== ce[k] || tick[1] !== te[k])
        $display("FAIL en4_e%0d clk1=%b tick1=%b want %b/%b",
                 k, clk_out[1], tick[1], ce[k], te[k]);
      else n_pass++;
    end
  endtask

  task automatic test_sync();
    bit [0:5] c0 = 6'b110001;
    bit [0:5] t0 = 6'b001000;
    do_sync();
    n_chk++;
    if (clk_out !== 2'b00 || tick !== 2'b00)
      $display("FAIL sync0 clk=%b tick=%b want 00/00", clk_out, tick);
    else n_pass++;
    cfg_valid = 1'b1;
    cfg_ch = 1'b0;
    cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    do_sync();
    n_chk++;
    if (clk_out !== 2'b00 || tick !== 2'b00)
      $display("FAIL sync1 clk=%b tick=%b want 00/00", clk_out, tick);
    else n_pass++;
    step();
    n_chk++;
    if (clk_out !== 2'b01)
      $display("FAIL sync_p1 clk=%b want 01", clk_out);
    else n_pass++;
    step();
    n_chk++;
    if (clk_out !== 2'b11)
      $display("FAIL sync_p2 clk=%b want 11", clk_out);
    else n_pass++;
    step();
    n_chk++;
    if (clk_out !== 2'b10 || tick !== 2'b01)
      $display("FAIL sync_p3 clk=%b tick=%b want 10/01", clk_out, tick);
    else n_pass++;
    cfg_valid = 1'b1;
    cfg_div = 8'd6;
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    cfg_valid = 1'b0;
    n_chk++;
    if (clk_out !== 2'b00 || cfg_ready !== 1'b0)
      $display("FAIL sync_wr clk=%b rdy=%b want 00/0", clk_out, cfg_ready);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      step();
      n_chk++;
      if (clk_out[0] !== c0[k] || tick[0] !== t0[k])
        $display("FAIL r6_e%0d clk0=%b tick0=%b want %b/%b",
                 k, clk_out[0], tick[0], c0[k], t0[k]);
      else n_pass++;
    end
    cfg_valid = 1'b1;
    cfg_ch = 1'b1;
    cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    n_chk++;
    if (cfg_ready !== 1'b0)
      $display("FAIL pend1 rdy=%b want 0", cfg_ready);
    else n_pass++;
    do_sync();
    n_chk++;
    if (cfg_ready !== 1'b1 || clk_out !== 2'b00)
      $display("FAIL sync_apply rdy=%b clk=%b want 1/00",
               cfg_ready, clk_out);
    else n_pass++;
    step();
    n_chk++;
    if (clk_out[1] !== 1'b1)
      $display("FAIL r2_a clk1=%b want 1", clk_out[1]);
    else n_pass++;
    step();
    n_chk++;
    if (clk_out[1] !== 1'b0 || tick[1] !== 1'b1)
      $display("FAIL r2_b clk1=%b tick1=%b want 0/1", clk_out[1], tick[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cfg_valid = 1'b1;
    cfg_ch = 1'b0;
    cfg_div = 8'd9;
    step();
    cfg_valid = 1'b0;
    n_chk++;
    if (cfg_ready !== 1'b0 || clk_out[1] !== 1'b1)
      $display("FAIL mid_pre rdy=%b clk1=%b want 0/1",
               cfg_ready, clk_out[1]);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (clk_out !== 2'b00 || tick !== 2'b00 || cfg_ready !== 1'b1)
      $display("FAIL mid_async clk=%b tick=%b rdy=%b want 00/00/1",
               clk_out, tick, cfg_ready);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    n_chk++;
    if (clk_out !== 2'b11 || tick !== 2'b00)
      $display("FAIL mid_e1 clk=%b tick=%b want 11/00", clk_out, tick);
    else n_pass++;
    step();
    n_chk++;
    if (clk_out !== 2'b00 || tick !== 2'b11)
      $display("FAIL mid_e2 clk=%b tick=%b want 00/11", clk_out, tick);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_default();
    test_write_ch0();
    test_disable();
    test_sync();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
